// File: rtl/writeback_regfile.sv
// writeback_regfile
// Write-back stage and architectural register file for the 5-stage RV32I pipeline.
// Picks the write-back value (link address, load data or ALU result), commits it
// into a 32 x 32-bit register file, serves two combinational read ports with
// same-cycle write-through bypass, and counts committed register writes.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-low reset (0 = asserted)
//   Ctl_MemtoReg_in select Read_Data as the write-back value
//   Ctl_RegWrite_in commit the write-back value to Rd_in
//   Rd_in           destination register index
//   jal_in/jalr_in  jump-and-link: write back PC_in + 4
//   Read_Data       load data from data memory
//   ALUresult_in    ALU result
//   PC_in           PC of the write-back instruction
//   Rs1/Rs2         read port indices
//   Read_data1/2    bypassed register values for Rs1/Rs2 (combinational)
//   WB_Data         selected write-back value, to the EX forwarding unit
//   WB_Rd           destination index, passed through
//   WB_RegWrite     effective write enable (never set for x0)
//   wr_count        number of committed register writes, wraps
module writeback_regfile #(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Ctl_MemtoReg_in,
  input  logic             Ctl_RegWrite_in,
  input  logic [4:0]       Rd_in,
  input  logic             jal_in,
  input  logic             jalr_in,
  input  logic [31:0]      Read_Data,
  input  logic [31:0]      ALUresult_in,
  input  logic [31:0]      PC_in,
  input  logic [4:0]       Rs1,
  input  logic [4:0]       Rs2,
  output logic [31:0]      Read_data1,
  output logic [31:0]      Read_data2,
  output logic [31:0]      WB_Data,
  output logic [4:0]       WB_Rd,
  output logic             WB_RegWrite,
  output logic [CNT_W-1:0] wr_count
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned IDX_W = 5;

  logic [XLEN-1:0] rf [NREG];

  // Write-back select: link address wins over load data, which wins over ALU.
  always_comb begin
    WB_Data = ALUresult_in;
    if (jal_in | jalr_in) begin
      WB_Data = PC_in + XLEN'(4);
    end else if (Ctl_MemtoReg_in) begin
      WB_Data = Read_Data;
    end
  end

  assign WB_Rd       = Rd_in;
  assign WB_RegWrite = Ctl_RegWrite_in & (Rd_in != IDX_W'(0));

  // Register array; x0 is never written because WB_RegWrite excludes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        rf[i] <= '0;
      end
    end else if (WB_RegWrite) begin
      rf[Rd_in] <= WB_Data;
    end
  end

  // Committed-write counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count <= '0;
    end else if (WB_RegWrite) begin
      wr_count <= wr_count + CNT_W'(1);
    end
  end

  // Read port 1: x0 forced to zero, then same-cycle bypass, then array.
  always_comb begin
    Read_data1 = rf[Rs1];
    if (Rs1 == IDX_W'(0)) begin
      Read_data1 = '0;
    end else if (WB_RegWrite && (Rd_in == Rs1)) begin
      Read_data1 = WB_Data;
    end
  end

  // Read port 2: same rule as port 1.
  always_comb begin
    Read_data2 = rf[Rs2];
    if (Rs2 == IDX_W'(0)) begin
      Read_data2 = '0;
    end else if (WB_RegWrite && (Rd_in == Rs2)) begin
      Read_data2 = WB_Data;
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: a default-width instance plus a
// CNT_W=4 instance sharing the same stimulus for the counter-wrap scenario.
module tb_writeback_regfile;

  logic        clk;
  logic        reset;
  logic        Ctl_MemtoReg_in;
  logic        Ctl_RegWrite_in;
  logic [4:0]  Rd_in;
  logic        jal_in;
  logic        jalr_in;
  logic [31:0] Read_Data;
  logic [31:0] ALUresult_in;
  logic [31:0] PC_in;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic [31:0] Read_data1;
  logic [31:0] Read_data2;
  logic [31:0] WB_Data;
  logic [4:0]  WB_Rd;
  logic        WB_RegWrite;
  logic [63:0] wr_count;

  logic [31:0] s_Read_data1;
  logic [31:0] s_Read_data2;
  logic [31:0] s_WB_Data;
  logic [4:0]  s_WB_Rd;
  logic        s_WB_RegWrite;
  logic [3:0]  s_wr_count;

  int errors;
  int checks;

  writeback_regfile dut (
    .clk             (clk),
    .reset           (reset),
    .Ctl_MemtoReg_in (Ctl_MemtoReg_in),
    .Ctl_RegWrite_in (Ctl_RegWrite_in),
    .Rd_in           (Rd_in),
    .jal_in          (jal_in),
    .jalr_in         (jalr_in),
    .Read_Data       (Read_Data),
    .ALUresult_in    (ALUresult_in),
    .PC_in           (PC_in),
    .Rs1             (Rs1),
    .Rs2             (Rs2),
    .Read_data1      (Read_data1),
    .Read_data2      (Read_data2),
    .WB_Data         (WB_Data),
    .WB_Rd           (WB_Rd),
    .WB_RegWrite     (WB_RegWrite),
    .wr_count        (wr_count)
  );

  writeback_regfile #(.CNT_W(4)) dut_small (
    .clk             (clk),
    .reset           (reset),
    .Ctl_MemtoReg_in (Ctl_MemtoReg_in),
    .Ctl_RegWrite_in (Ctl_RegWrite_in),
    .Rd_in           (Rd_in),
    .jal_in          (jal_in),
    .jalr_in         (jalr_in),
    .Read_Data       (Read_Data),
    .ALUresult_in    (ALUresult_in),
    .PC_in           (PC_in),
    .Rs1             (Rs1),
    .Rs2             (Rs2),
    .Read_data1      (s_Read_data1),
    .Read_data2      (s_Read_data2),
    .WB_Data         (s_WB_Data),
    .WB_Rd           (s_WB_Rd),
    .WB_RegWrite     (s_WB_RegWrite),
    .wr_count        (s_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one write-back instruction (inputs only; no checking).
  task automatic drive(input logic rw, input logic m2r, input logic jl, input logic jlr,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc);
    Ctl_RegWrite_in = rw;
    Ctl_MemtoReg_in = m2r;
    jal_in          = jl;
    jalr_in         = jlr;
    Rd_in           = rd;
    ALUresult_in    = alu;
    Read_Data       = rdata;
    PC_in           = pc;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  // Simple ALU write presented at a negedge and committed at the next posedge.
  task automatic alu_write(input logic [4:0] rd, input logic [31:0] val);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, rd, val, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    checks++;
    if (Read_data1 !== 32'h0) begin
      errors++; $display("FAIL reset_rd1: got %h want %h", Read_data1, 32'h0);
    end
    checks++;
    if (wr_count !== 64'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", wr_count);
    end
    alu_write(5'd5, 32'hDEADBEEF);
    Rs1 = 5'd5;
    #1;
    checks++;
    if (Read_data1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL x5_written: got %h want %h", Read_data1, 32'hDEADBEEF);
    end
    checks++;
    if (wr_count !== 64'd1) begin
      errors++; $display("FAIL count_one: got %0d want 1", wr_count);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (Read_data1 !== 32'h0) begin
      errors++; $display("FAIL x5_after_reset: got %h want %h", Read_data1, 32'h0);
    end
    checks++;
    if (wr_count !== 64'd0) begin
      errors++; $display("FAIL count_after_reset: got %0d want 0", wr_count);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (Read_data1 !== 32'h0) begin
      errors++; $display("FAIL x5_post_release: got %h want %h", Read_data1, 32'h0);
    end
  endtask

  task automatic test_alu_bypass();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h00000123, 32'h0, 32'h0);
    Rs1 = 5'd3;
    #1;
    checks++;
    if (Read_data1 !== 32'h123) begin
      errors++; $display("FAIL alu_bypass: got %h want %h", Read_data1, 32'h123);
    end
    checks++;
    if (WB_Rd !== 5'd3 || WB_RegWrite !== 1'b1) begin
      errors++; $display("FAIL wb_ctl: got rd=%0d we=%b want rd=3 we=1", WB_Rd, WB_RegWrite);
    end
    @(posedge clk);
    #1;
    idle();
    #1;
    checks++;
    if (Read_data1 !== 32'h123) begin
      errors++; $display("FAIL alu_committed: got %h want %h", Read_data1, 32'h123);
    end
    checks++;
    if (wr_count !== 64'd1) begin
      errors++; $display("FAIL alu_count: got %0d want 1", wr_count);
    end
  endtask

  task automatic test_select_priority();
    Rs1 = 5'd1;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 32'h99, 32'h55, 32'h00000040);
    #1;
    checks++;
    if (WB_Data !== 32'h44) begin
      errors++; $display("FAIL sel_jal: got %h want %h", WB_Data, 32'h44);
    end
    @(posedge clk); #1; idle(); #1;
    checks++;
    if (Read_data1 !== 32'h44) begin
      errors++; $display("FAIL x1_jal: got %h want %h", Read_data1, 32'h44);
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 32'h99, 32'h55, 32'h00000040);
    @(posedge clk); #1; idle(); #1;
    checks++;
    if (Read_data1 !== 32'h55) begin
      errors++; $display("FAIL x1_load: got %h want %h", Read_data1, 32'h55);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'h99, 32'h55, 32'h00000040);
    #1;
    checks++;
    if (WB_Data !== 32'h99) begin
      errors++; $display("FAIL sel_alu: got %h want %h", WB_Data, 32'h99);
    end
    @(posedge clk); #1; idle();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 32'h99, 32'h55, 32'hFFFFFFFC);
    @(posedge clk); #1; idle(); #1;
    checks++;
    if (Read_data1 !== 32'h0) begin
      errors++; $display("FAIL x1_jalr_wrap: got %h want %h", Read_data1, 32'h0);
    end
    checks++;
    if (wr_count !== 64'd5) begin
      errors++; $display("FAIL select_count: got %0d want 5", wr_count);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0);
    Rs1 = 5'd0;
    Rs2 = 5'd0;
    #1;
    checks++;
    if (Read_data1 !== 32'h0 || Read_data2 !== 32'h0) begin
      errors++; $display("FAIL x0_bypass: got %h/%h want 0/0", Read_data1, Read_data2);
    end
    checks++;
    if (WB_RegWrite !== 1'b0) begin
      errors++; $display("FAIL x0_we: got %b want 0", WB_RegWrite);
    end
    @(posedge clk); #1; idle(); #1;
    checks++;
    if (Read_data1 !== 32'h0 || Read_data2 !== 32'h0) begin
      errors++; $display("FAIL x0_after: got %h/%h want 0/0", Read_data1, Read_data2);
    end
    checks++;
    if (wr_count !== 64'd5) begin
      errors++; $display("FAIL x0_count: got %0d want 5", wr_count);
    end
  endtask

  task automatic test_dual_bypass();
    alu_write(5'd7, 32'h11);
    alu_write(5'd8, 32'h33);
    Rs1 = 5'd7;
    Rs2 = 5'd8;
    #1;
    checks++;
    if (Read_data1 !== 32'h11) begin
      errors++; $display("FAIL x7_preload: got %h want %h", Read_data1, 32'h11);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h22, 32'h0, 32'h0);
    #1;
    checks++;
    if (Read_data1 !== 32'h22 || Read_data2 !== 32'h33) begin
      errors++; $display("FAIL dual_mixed: got %h/%h want 22/33", Read_data1, Read_data2);
    end
    Rs2 = 5'd7;
    #1;
    checks++;
    if (Read_data1 !== 32'h22 || Read_data2 !== 32'h22) begin
      errors++; $display("FAIL dual_same: got %h/%h want 22/22", Read_data1, Read_data2);
    end
    @(posedge clk); #1; idle(); #1;
    checks++;
    if (Read_data2 !== 32'h22) begin
      errors++; $display("FAIL x7_committed: got %h want %h", Read_data2, 32'h22);
    end
  endtask

  task automatic test_counter_wrap();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (s_wr_count !== 4'd0) begin
      errors++; $display("FAIL wrap_reset: got %0d want 0", s_wr_count);
    end
    for (int n = 1; n <= 17; n++) begin
      alu_write(5'd9, 32'(n));
      if (n == 15) begin
        checks++;
        if (s_wr_count !== 4'd15) begin
          errors++; $display("FAIL wrap_15: got %0d want 15", s_wr_count);
        end
      end else if (n == 16) begin
        checks++;
        if (s_wr_count !== 4'd0) begin
          errors++; $display("FAIL wrap_16: got %0d want 0", s_wr_count);
        end
      end else if (n == 17) begin
        checks++;
        if (s_wr_count !== 4'd1) begin
          errors++; $display("FAIL wrap_17: got %0d want 1", s_wr_count);
        end
      end
    end
    checks++;
    if (wr_count !== 64'd17) begin
      errors++; $display("FAIL wide_count: got %0d want 17", wr_count);
    end
    Rs1 = 5'd9;
    #1;
    checks++;
    if (Read_data1 !== 32'd17) begin
      errors++; $display("FAIL x9_last: got %h want %h", Read_data1, 32'd17);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    Rs1    = 5'd5;
    Rs2    = 5'd0;
    idle();
    #12;
    test_reset_start();
    test_reset();
    test_alu_bypass();
    test_select_priority();
    test_x0();
    test_dual_bypass();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Release the power-on reset away from a rising edge.
  task automatic test_reset_start();
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

endmodule
